// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: pulls a burst of bytes from an upstream FIFO through a 2-entry skid buffer onto a valid/ready stream.
// Ports: clk/rst_n clock and async active-low reset; start/burst_len begin a burst (IDLE only); abort ends it early;
//   fifo_empty/fifo_rd_en/fifo_rd_data/fifo_rd_valid upstream read side (data one cycle after rd_en);
//   m_data/m_valid/m_ready output stream; busy (READ/DRAIN), done (one-cycle pulse), byte_cnt (bytes delivered).
module fifo_rd_ctrl #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              abort,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  byte_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [LEN_W-1:0] r_len, r_recv, r_cnt;
  logic r_inflight;
  logic [1:0] r_occ, w_occ_net, w_occ_next;
  logic [DATA_W-1:0] r_buf0, r_buf1, w_buf0_next, w_buf1_next;
  logic w_active, w_flush, w_pop, w_push;
  assign w_active = (r_state == S_READ) || (r_state == S_DRAIN);
  assign w_flush = w_active && abort;
  assign w_pop = m_valid && m_ready;
  assign w_push = (r_state == S_READ) && r_inflight && fifo_rd_valid && !abort;
  // Occupancy net of this cycle's pop: lets a new read issue while the head leaves, giving one byte per cycle.
  assign w_occ_net = r_occ - {1'b0, w_pop};
  assign fifo_rd_en = (r_state == S_READ) && !abort && !fifo_empty &&
                      (({1'b0, w_occ_net} + {2'b00, r_inflight}) < 3'd2) &&
                      (({1'b0, r_recv} + (LEN_W+1)'(r_inflight)) < {1'b0, r_len});
  // Head lives in buf0; a pop shifts buf1 down, a push lands in the first free slot after the pop.
  assign w_buf0_next = (w_push && w_occ_net == 2'd0) ? fifo_rd_data : w_pop ? r_buf1 : r_buf0;
  assign w_buf1_next = (w_push && w_occ_net != 2'd0) ? fifo_rd_data : r_buf1;
  assign w_occ_next = w_flush ? 2'd0 : w_occ_net + {1'b0, w_push};
  assign m_data = r_buf0;
  assign m_valid = r_occ != 2'd0;
  assign busy = w_active;
  assign done = r_state == S_DONE;
  assign byte_cnt = r_cnt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (burst_len == '0) ? S_DONE : S_READ;
      S_READ:  if (abort) w_next = S_DONE;
               else if (r_recv == r_len && !r_inflight) w_next = S_DRAIN;
      S_DRAIN: if (abort || r_occ == 2'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len <= '0;
      r_recv <= '0;
      r_cnt <= '0;
      r_inflight <= 1'b0;
      r_occ <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      r_state <= w_next;
      r_inflight <= fifo_rd_en;
      r_occ <= w_occ_next;
      r_buf0 <= w_buf0_next;
      r_buf1 <= w_buf1_next;
      if (r_state == S_IDLE && start) begin
        r_len <= burst_len;
        r_recv <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_recv <= r_recv + LEN_W'(1);
        if (w_pop) r_cnt <= r_cnt + LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: drives fifo_rd_ctrl from a queue-based FIFO model and checks the delivered stream.
module tb_fifo_rd_ctrl;
  localparam int DW = 8;
  localparam int LW = 9;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic fifo_empty = 1'b1, fifo_rd_valid = 1'b0, m_ready = 1'b1;
  logic [LW-1:0] burst_len = '0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic fifo_rd_en, m_valid, busy, done;
  logic [DW-1:0] m_data;
  logic [LW-1:0] byte_cnt;
  int total = 0, bad = 0;
  int cyc = 0, hs = 0, done_cnt = 0, done_cyc = 0, first_hs_cyc = 0, last_hs_cyc = 0;
  int rd_hi = 0, rd_pop = 0, drops = 0, max_out = 0, hold_bad = 0, empty_rd = 0, start_cyc = 0;
  bit pend_v = 0, drop_en = 0, hold_v = 0;
  logic [7:0] pend = '0, hold_d = '0;
  logic [7:0] fifo_q[$], feed[$], out_q[$], exp_q[$];

  fifo_rd_ctrl #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_valid(fifo_rd_valid), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .byte_cnt(byte_cnt));

  always #5 clk = ~clk;

  // Observation point: half a cycle after each edge, everything combinational has settled.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) hold_v = 0;
    else begin
      if (fifo_rd_en) begin
        rd_hi++;
        if (fifo_empty || fifo_q.size() == 0) empty_rd++;
        else begin pend = fifo_q.pop_front(); pend_v = 1; rd_pop++; end
      end
      if (m_valid && m_ready) begin
        if (hs == 0) first_hs_cyc = cyc;
        out_q.push_back(m_data); hs++; last_hs_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (hold_v && m_valid && m_data !== hold_d) hold_bad++;
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      if (rd_pop - drops - hs > max_out) max_out = rd_pop - drops - hs;
    end
  end

  // FIFO read response: data one cycle after the read; a dropped read leaves the byte in the FIFO.
  always @(posedge clk) begin
    #1;
    if (pend_v) begin
      pend_v = 0;
      fifo_rd_data = pend;
      if (drop_en && $urandom_range(0, 3) == 0) begin
        fifo_rd_valid = 1'b0; drops++; fifo_q.push_front(pend);
      end else fifo_rd_valid = 1'b1;
    end else fifo_rd_valid = 1'b0;
    fifo_empty = fifo_q.size() == 0;
  end

  task automatic clr();
    out_q.delete(); exp_q.delete(); fifo_q.delete(); feed.delete();
    hs = 0; done_cnt = 0; done_cyc = 0; first_hs_cyc = 0; last_hs_cyc = 0;
    rd_hi = 0; rd_pop = 0; drops = 0; max_out = 0; hold_bad = 0; empty_rd = 0;
    fifo_empty = 1'b1; drop_en = 0; m_ready = 1'b1;
  endtask

  task automatic run_burst(input int len, input bit rnd, input int delay);
    bit ok = 0;
    @(posedge clk); #1;
    start = 1'b1; burst_len = LW'(len); start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt > 0) begin ok = 1; break; end
      if (i >= delay && feed.size() != 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
        fifo_q.push_back(feed.pop_front()); fifo_empty = 1'b0;
      end
      if (rnd) m_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    total++;
    if (!ok) begin bad++; $display("FAIL burst_timeout len=%0d got=no_done want=done", len); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string name);
    int nb = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) nb++;
    total++;
    if (nb != 0 || out_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s stream got_len=%0d want_len=%0d wrong_bytes=%0d", name, out_q.size(), exp_q.size(), nb);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pend_v = 0; clr();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({fifo_rd_en, m_valid, busy, done} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {fifo_rd_en, m_valid, busy, done});
    end
    total++;
    if (m_data !== '0 || byte_cnt !== '0) begin
      bad++; $display("FAIL reset_values got data=%h cnt=%0d want 0/0", m_data, byte_cnt);
    end
  endtask

  task automatic test_basic();
    clr();
    for (int i = 1; i <= 4; i++) begin exp_q.push_back(8'(i)); fifo_q.push_back(8'(i)); end
    fifo_empty = 1'b0;
    run_burst(4, 0, 0);
    check_stream("basic");
    total++;
    if (last_hs_cyc - first_hs_cyc != 3) begin
      bad++; $display("FAIL basic_rate got=%0d want=3 cycles first..last", last_hs_cyc - first_hs_cyc);
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL basic_done got=%0d want=1", done_cnt); end
    total++;
    if (byte_cnt !== 9'd4) begin bad++; $display("FAIL basic_cnt got=%0d want=4", byte_cnt); end
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    clr();
    m_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin exp_q.push_back(8'(i)); fifo_q.push_back(8'(i)); end
    fifo_empty = 1'b0;
    @(posedge clk); #1; start = 1'b1; burst_len = 9'd3;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL bp_first_valid got=0 want=1"); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (m_valid !== 1'b1 || m_data !== 8'h01) begin
        bad++; $display("FAIL bp_hold cycle=%0d got v=%b d=%h want v=1 d=01", i, m_valid, m_data);
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin @(posedge clk); #1; end
    repeat (3) @(posedge clk);
    #1;
    check_stream("bp");
    total++;
    if (max_out > 2) begin bad++; $display("FAIL bp_outstanding got=%0d want<=2", max_out); end
    total++;
    if (done_cnt != 1 || done_cyc <= last_hs_cyc || hs != 3) begin
      bad++; $display("FAIL bp_done got done=%0d at %0d last_xfer=%0d xfers=%0d want 1 after 3rd", done_cnt, done_cyc, last_hs_cyc, hs);
    end
    total++;
    if (byte_cnt !== 9'd3) begin bad++; $display("FAIL bp_cnt got=%0d want=3", byte_cnt); end
  endtask

  task automatic test_empty_start();
    clr();
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
    feed = exp_q;
    run_burst(2, 0, 10);
    total++;
    if (empty_rd != 0) begin bad++; $display("FAIL empty_rd_en got=%0d want=0", empty_rd); end
    check_stream("empty");
    total++;
    if (done_cnt != 1 || byte_cnt !== 9'd2) begin
      bad++; $display("FAIL empty_done got done=%0d cnt=%0d want 1/2", done_cnt, byte_cnt);
    end
  endtask

  task automatic test_zero_len();
    clr();
    fifo_q.push_back(8'h77); fifo_empty = 1'b0;
    run_burst(0, 0, 0);
    total++;
    if (rd_hi != 0) begin bad++; $display("FAIL zero_rd_en got=%0d want=0", rd_hi); end
    total++;
    if (done_cnt != 1 || done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
      bad++; $display("FAIL zero_done got count=%0d delay=%0d want 1 within 2", done_cnt, done_cyc - start_cyc);
    end
    total++;
    if (byte_cnt !== '0) begin bad++; $display("FAIL zero_cnt got=%0d want=0", byte_cnt); end
  endtask

  task automatic test_abort();
    bit hit = 0;
    clr();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    fifo_empty = 1'b0;
    @(posedge clk); #1; start = 1'b1; burst_len = 9'd8;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (hs >= 2) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    total++;
    if (!hit || hs != 2) begin bad++; $display("FAIL abort_setup got xfers=%0d want=2", hs); end
    m_ready = 1'b0; abort = 1'b1;
    #1;
    total++;
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL abort_rd_en got=%b want=0", fifo_rd_en); end
    @(posedge clk); #1;
    abort = 1'b0;
    total++;
    if (m_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_next got v=%b done=%b busy=%b want 0/1/0", m_valid, done, busy);
    end
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (byte_cnt !== 9'd2 || done_cnt != 1) begin
      bad++; $display("FAIL abort_cnt got cnt=%0d done=%0d want 2/1", byte_cnt, done_cnt);
    end
    check_stream("abort");
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      int len = $urandom_range(1, 24);
      int pre = $urandom_range(0, len);
      clr();
      drop_en = 1;
      for (int i = 0; i < len; i++) exp_q.push_back(8'($urandom));
      for (int i = 0; i < len; i++)
        if (i < pre) fifo_q.push_back(exp_q[i]); else feed.push_back(exp_q[i]);
      fifo_empty = fifo_q.size() == 0;
      run_burst(len, 1, 0);
      check_stream("random");
      total++;
      if (byte_cnt !== LW'(len) || done_cnt != 1) begin
        bad++; $display("FAIL random_cnt burst=%0d got cnt=%0d done=%0d want %0d/1", b, byte_cnt, done_cnt, len);
      end
      total++;
      if (max_out > 2 || empty_rd != 0 || hold_bad != 0 || fifo_q.size() != 0) begin
        bad++; $display("FAIL random_rules burst=%0d got out=%0d empty_rd=%0d hold=%0d left=%0d want <=2/0/0/0", b, max_out, empty_rd, hold_bad, fifo_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    clr();
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'hA1 + 8'(i));
    fifo_empty = 1'b0;
    @(posedge clk); #1; start = 1'b1; burst_len = 9'd6;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1 m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({fifo_rd_en, m_valid, busy, done} !== 4'b0 || m_data !== '0 || byte_cnt !== '0) begin
      bad++; $display("FAIL reset_mid got en=%b v=%b busy=%b done=%b d=%h cnt=%0d want all 0", fifo_rd_en, m_valid, busy, done, m_data, byte_cnt);
    end
    clr(); pend_v = 0;
    #3 rst_n = 1'b1;
    fifo_q.push_back(8'h33); fifo_empty = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || rd_hi != 0 || m_valid !== 1'b0) begin
      bad++; $display("FAIL reset_idle got busy=%b reads=%0d v=%b want 0/0/0", busy, rd_hi, m_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_start();
    test_zero_len();
    test_abort();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
